// File: rtl/coeff_pkg.sv
// Shared coefficient-link definitions for the coefficient dispatcher and collector.
// COEFF_DISPATCH_CHECKSUM_EN adds the CSUM state and the checksum helper.
package coeff_pkg;

    localparam int unsigned NUM_COEFF = 9;
    localparam int unsigned COEFF_W   = 9;
    localparam int unsigned IDX_W     = $clog2(NUM_COEFF + 1);

    typedef logic [COEFF_W-1:0] coeff_t;
    typedef logic [IDX_W-1:0]   coeff_idx_t;

    localparam coeff_idx_t LAST_IDX = coeff_idx_t'(NUM_COEFF - 1);
    localparam coeff_idx_t CSUM_IDX = coeff_idx_t'(NUM_COEFF);

`ifdef COEFF_DISPATCH_CHECKSUM_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        CSUM = 2'd2
    } state_t;

    // Modulo-2^COEFF_W sum of the raw coefficient bit patterns.
    function automatic coeff_t coeff_sum(input logic [NUM_COEFF-1:0][COEFF_W-1:0] c);
        coeff_t s;
        s = '0;
        for (int unsigned i = 0; i < NUM_COEFF; i++) begin
            s = s + c[i];
        end
        return s;
    endfunction
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1
    } state_t;
`endif

endpackage

// File: rtl/coeff_dispatch.sv
// Streams one captured coefficient set out one coefficient per beat over valid/ready.
// Define COEFF_DISPATCH_CHECKSUM_EN to append a checksum beat after the last coefficient.
module coeff_dispatch
    import coeff_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              load_valid,
    output logic                              load_ready,
    input  logic [NUM_COEFF-1:0][COEFF_W-1:0] load_coeffs,
    output logic                              dst_valid,
    input  logic                              dst_ready,
    output logic [COEFF_W-1:0]                dst_data,
    output logic [IDX_W-1:0]                  dst_idx,
    output logic                              dst_last,
    output logic                              busy
);

    state_t     state;
    coeff_idx_t idx;
    coeff_t     coeff_r [NUM_COEFF];
    logic       capture;

    assign capture = (state == IDLE) && load_valid;

`ifdef COEFF_DISPATCH_CHECKSUM_EN
    coeff_t csum_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            csum_r <= '0;
        end else if (capture) begin
            csum_r <= coeff_sum(load_coeffs);
        end
    end
`endif

    // Capture array needs no reset: it is only observable after a load.
    always_ff @(posedge clk) begin
        if (!rst && capture) begin
            for (int unsigned i = 0; i < NUM_COEFF; i++) begin
                coeff_r[i] <= load_coeffs[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        idx   <= '0;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (dst_ready) begin
                        if (idx == LAST_IDX) begin
`ifdef COEFF_DISPATCH_CHECKSUM_EN
                            state <= CSUM;
`else
                            state <= IDLE;
`endif
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
`ifdef COEFF_DISPATCH_CHECKSUM_EN
                CSUM: begin
                    if (dst_ready) begin
                        state <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode registered state only; dst_ready never reaches them combinationally.
    always_comb begin
        load_ready = (state == IDLE);
        busy       = (state != IDLE);
        dst_valid  = 1'b0;
        dst_data   = '0;
        dst_idx    = '0;
        dst_last   = 1'b0;
        case (state)
            SEND: begin
                dst_valid = 1'b1;
                dst_data  = coeff_r[idx];
                dst_idx   = idx;
`ifndef COEFF_DISPATCH_CHECKSUM_EN
                dst_last  = (idx == LAST_IDX);
`endif
            end
`ifdef COEFF_DISPATCH_CHECKSUM_EN
            CSUM: begin
                dst_valid = 1'b1;
                dst_data  = csum_r;
                dst_idx   = CSUM_IDX;
                dst_last  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_coeff_dispatch.sv
// Scoreboard bench for coeff_dispatch: stimulus pushes expected beats, a monitor pops on transfer.
// Build with COEFF_DISPATCH_CHECKSUM_EN to also expect the checksum beat.
module tb_coeff_dispatch;
    import coeff_pkg::*;

`ifdef COEFF_DISPATCH_CHECKSUM_EN
    localparam int NBEATS = 10;
    localparam bit CSUM_ON = 1'b1;
`else
    localparam int NBEATS = 9;
    localparam bit CSUM_ON = 1'b0;
`endif

    typedef struct {
        int data;
        int idx;
        int last;
    } beat_t;

    logic                              clk = 1'b0;
    logic                              rst = 1'b1;
    logic                              load_valid = 1'b0;
    logic                              load_ready;
    logic [NUM_COEFF-1:0][COEFF_W-1:0] load_coeffs = '0;
    logic                              dst_valid;
    logic                              dst_ready = 1'b0;
    logic [COEFF_W-1:0]                dst_data;
    logic [IDX_W-1:0]                  dst_idx;
    logic                              dst_last;
    logic                              busy;

    beat_t exp_q [$];
    int    n_tests = 0;
    int    n_fail  = 0;

    coeff_dispatch dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_coeffs(load_coeffs),
        .dst_valid  (dst_valid),
        .dst_ready  (dst_ready),
        .dst_data   (dst_data),
        .dst_idx    (dst_idx),
        .dst_last   (dst_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: beats are the coefficients in order, then optionally their sum mod 2^9.
    task automatic push_expected(input logic [8:0] c [9]);
        int s;
        s = 0;
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back('{data: int'(c[i]), idx: i, last: (i == 8 && !CSUM_ON) ? 1 : 0});
            s += int'(c[i]);
        end
        if (CSUM_ON) exp_q.push_back('{data: s % 512, idx: 9, last: 1});
    endtask

    // Monitor: stall stability and scoreboard pop on every transfer.
    initial begin
        bit    prev_stall;
        int    p_data, p_idx, p_last;
        beat_t b;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", int'(dst_valid), 1);
                    check("stall_data", int'(dst_data), p_data);
                    check("stall_idx", int'(dst_idx), p_idx);
                    check("stall_last", int'(dst_last), p_last);
                end
                if (dst_valid && dst_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat_idx", int'(dst_idx), -1);
                    end else begin
                        b = exp_q.pop_front();
                        check("beat_data", int'(dst_data), b.data);
                        check("beat_idx", int'(dst_idx), b.idx);
                        check("beat_last", int'(dst_last), b.last);
                    end
                end
                prev_stall = dst_valid && !dst_ready;
                p_data = int'(dst_data);
                p_idx  = int'(dst_idx);
                p_last = int'(dst_last);
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_load_ready"}, int'(load_ready), 1);
        check({tag, "_dst_valid"}, int'(dst_valid), 0);
        check({tag, "_dst_data"}, int'(dst_data), 0);
        check({tag, "_dst_idx"}, int'(dst_idx), 0);
        check({tag, "_dst_last"}, int'(dst_last), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    // mode 0: ready held 1, mode 1: ready alternates starting 0, mode 2: random ready.
    task automatic run_set(input logic [8:0] c [9], input int mode, input int rst_at, input int ign_at);
        int cyc;
        bit phase;
        cyc = 0;
        while (!load_ready && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        if (!load_ready) begin
            check("wait_load_ready", int'(load_ready), 1);
            return;
        end
        for (int i = 0; i < 9; i++) load_coeffs[i] = c[i];
        load_valid = 1'b1;
        dst_ready  = (mode == 0);
        push_expected(c);
        @(posedge clk); #1;
        load_valid = 1'b0;
        for (int i = 0; i < 9; i++) load_coeffs[i] = 9'($urandom);
        cyc   = 0;
        phase = 1'b0;
        while (exp_q.size() != 0 && cyc < 200) begin
            check("busy_in_flight", int'(busy), 1);
            check("load_ready_in_flight", int'(load_ready), 0);
            if (rst_at >= 0 && dst_valid && int'(dst_idx) == rst_at) begin
                dst_ready  = 1'b0;
                rst        = 1'b1;
                load_valid = 1'b1;
                @(posedge clk); #1;
                rst        = 1'b0;
                load_valid = 1'b0;
                check_idle_outputs("mid_reset");
                exp_q.delete();
                @(posedge clk); #1;
                check("post_reset_no_capture_busy", int'(busy), 0);
                return;
            end
            load_valid = (ign_at >= 0 && dst_valid && int'(dst_idx) == ign_at);
            case (mode)
                0:       dst_ready = 1'b1;
                1:       begin dst_ready = phase; phase = !phase; end
                default: dst_ready = 1'($urandom_range(0, 1));
            endcase
            @(posedge clk); #1;
            cyc++;
        end
        load_valid = 1'b0;
        if (exp_q.size() != 0) begin
            check("set_timeout_remaining", exp_q.size(), 0);
            exp_q.delete();
            return;
        end
        if (mode == 0) check("cycles_full_rate", cyc, NBEATS);
        if (mode == 1) check("cycles_alternating", cyc, 2 * NBEATS);
        check("done_load_ready", int'(load_ready), 1);
        check("done_dst_valid", int'(dst_valid), 0);
    endtask

    initial begin
        logic [8:0] c [9];
        logic [8:0] seq [9];

        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) seq[i] = 9'(i + 1);

        run_set(seq, 0, -1, -1);
        c = '{9'h100, 9'h1FF, 9'h0FF, 9'h000, 9'h001, 9'h1FE, 9'h002, 9'h180, 9'h07F};
        run_set(c, 0, -1, -1);
        run_set(seq, 1, -1, -1);
        run_set(seq, 0, -1, 3);
        run_set(seq, 0, 4, -1);
        run_set(seq, 0, -1, -1);
        for (int i = 0; i < 9; i++) c[i] = 9'h1FF;
        run_set(c, 0, -1, -1);

        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 9; i++) c[i] = 9'($urandom);
            run_set(c, (t % 3 == 0) ? 1 : 2, -1, (t % 4 == 1) ? int'($urandom_range(0, 8)) : -1);
        end

        dst_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("final_idle_busy", int'(busy), 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
